// File: rtl/i2s_clk_pkg.sv
// Shared types and constants for the I2S clock-enable generator.
// Included by the generator, its interface users and the bench.
package i2s_clk_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLDOFF = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam int RATE_48K  = 0;
   localparam int RATE_96K  = 1;
   localparam int RATE_192K = 2;

   // Index of the cnt bit whose toggle rate gives per_frame cycles per frame.
   function automatic int div_bit(input int sys_ratio, input int per_frame);
      return $clog2(sys_ratio / per_frame) - 1;
   endfunction

endpackage

// File: rtl/i2s_clk_div_if.sv
// Control and clock/strobe bundle between the I2S clock generator
// (master side) and the serialiser / control logic (slave side).
interface i2s_clk_div_if #(
   parameter int RATE_W = 2
);

   // en is a level request, running its acknowledge. running rises only after
   // the lock hold-off and falls the cycle after en or lock drops. Strobes and
   // clock outputs carry meaning only while running is high.
   logic              en;
   logic [RATE_W-1:0] rate_sel;
   logic [RATE_W-1:0] rate_cur;
   logic              running;
   logic              mclk;
   logic              sclk;
   logic              lrck;
   logic              sclk_fall_stb;
   logic              sclk_rise_stb;
   logic              frame_stb;

   modport master (
      input  en, rate_sel,
      output rate_cur, running, mclk, sclk, lrck,
             sclk_fall_stb, sclk_rise_stb, frame_stb
   );

   modport slave (
      output en, rate_sel,
      input  rate_cur, running, mclk, sclk, lrck,
             sclk_fall_stb, sclk_rise_stb, frame_stb
   );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for slow level signals entering clk.
// Both stages reset to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/i2s_clk_div.sv
// I2S MCLK/SCLK/LRCK generator: one free-running frame counter whose bits are
// the clock outputs, with registered edge strobes and frame-aligned rate switch.
module i2s_clk_div
   import i2s_clk_pkg::*;
#(
   parameter int SYS_FS_RATIO   = 2048,
   parameter int MCLK_PER_FRAME = 256,
   parameter int BCLK_PER_FRAME = 64,
   parameter int RATE_W         = 2,
   parameter int HOLDOFF_CYCLES = 256
) (
   input  logic            clk_in,
   input  logic            rst,
   input  logic            locked_in,
   i2s_clk_div_if.master   bus,
   output state_t          state_dbg
);

   localparam int W        = $clog2(SYS_FS_RATIO);
   localparam int MCLK_BIT = div_bit(SYS_FS_RATIO, MCLK_PER_FRAME);
   localparam int SCLK_BIT = div_bit(SYS_FS_RATIO, BCLK_PER_FRAME);
   localparam int MAX_RATE = $clog2(SYS_FS_RATIO / MCLK_PER_FRAME) - 1;
   localparam int HC_W     = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   localparam logic [RATE_W-1:0] MAX_RATE_V = RATE_W'(MAX_RATE);
   localparam logic [HC_W-1:0]   HOLD_LAST  = HC_W'(HOLDOFF_CYCLES - 1);

   state_t            state, state_next;
   logic [W-1:0]      cnt, cnt_next;
   logic [W:0]        sum;
   logic [HC_W-1:0]   hold_cnt, hold_next;
   logic [RATE_W-1:0] rate_cur, rate_next, rate_sat;
   logic              wrap;
   logic              lock_s;
   logic              fall_q, rise_q, frame_q;
   logic              fall_d, rise_d, frame_d;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk (clk_in),
      .rst (rst),
      .d   (locked_in),
      .q   (lock_s)
   );

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         hold_cnt <= '0;
         rate_cur <= '0;
         fall_q   <= 1'b0;
         rise_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         hold_cnt <= hold_next;
         rate_cur <= rate_next;
         fall_q   <= fall_d;
         rise_q   <= rise_d;
         frame_q  <= frame_d;
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      cnt_next   = '0;
      rate_next  = rate_cur;
      wrap       = 1'b0;
      rate_sat   = (bus.rate_sel > MAX_RATE_V) ? MAX_RATE_V : bus.rate_sel;
      sum        = {1'b0, cnt} + ((W + 1)'(1) << rate_cur);

      case (state)
         IDLE: begin
            rate_next = rate_sat;
            hold_next = '0;
            if (lock_s && bus.en) state_next = HOLDOFF;
         end
         HOLDOFF: begin
            rate_next = rate_sat;
            if (!lock_s || !bus.en)      state_next = IDLE;
            else if (hold_cnt == HOLD_LAST) state_next = RUN;
            else                         hold_next = hold_cnt + 1'b1;
         end
         RUN: begin
            // Rate only switches where the counter wraps, so no period is cut short.
            wrap = sum[W];
            if (wrap) rate_next = rate_sat;
            if (!lock_s || !bus.en) state_next = IDLE;
            else                    cnt_next   = sum[W-1:0];
         end
         default: state_next = IDLE;
      endcase

      // Strobes flag the edge the output bits will show after this update.
      fall_d  = (state_next == RUN) && cnt[SCLK_BIT] && !cnt_next[SCLK_BIT];
      rise_d  = (state_next == RUN) && !cnt[SCLK_BIT] && cnt_next[SCLK_BIT];
      frame_d = (state_next == RUN) && cnt[W-1] && !cnt_next[W-1];
   end

   assign bus.mclk          = cnt[MCLK_BIT];
   assign bus.sclk          = cnt[SCLK_BIT];
   assign bus.lrck          = cnt[W-1];
   assign bus.sclk_fall_stb = fall_q;
   assign bus.sclk_rise_stb = rise_q;
   assign bus.frame_stb     = frame_q;
   assign bus.rate_cur      = rate_cur;
   assign bus.running       = (state == RUN);
   assign state_dbg         = state;

endmodule

// File: tb/tb_i2s_clk_div.sv
// Directed bench for i2s_clk_div: a vector table of hand-computed output words
// plus period and strobe-count measurements at two rates.
module tb_i2s_clk_div;
   import i2s_clk_pkg::*;

   logic   clk_in = 1'b0;
   logic   rst;
   logic   locked_in;
   state_t state_dbg;

   i2s_clk_div_if #(.RATE_W(2)) bus ();

   i2s_clk_div dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .locked_in (locked_in),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;

   // ---------------- bookkeeping ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      string       name;
      int          adv;
      logic        rst;
      logic        lk;
      logic        en;
      logic [1:0]  sel;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[$];

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic r, input logic l, input logic e, input logic [1:0] s);
      rst          = r;
      locked_in    = l;
      bus.en       = e;
      bus.rate_sel = s;
   endtask

   task automatic add(input string name, input int adv, input logic r, input logic l,
                      input logic e, input logic [1:0] s, input state_t st,
                      input logic [8:0] w);
      vec_t v;
      v.name = name; v.adv = adv; v.rst = r; v.lk = l; v.en = e; v.sel = s;
      v.exp  = {st, w};
      vecs.push_back(v);
   endtask

   // {state, running, rate_cur, mclk, sclk, lrck, fall_stb, rise_stb, frame_stb}
   function automatic logic [10:0] obs();
      return {state_dbg, bus.running, bus.rate_cur, bus.mclk, bus.sclk, bus.lrck,
              bus.sclk_fall_stb, bus.sclk_rise_stb, bus.frame_stb};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // Aligns on a frame strobe, then measures one frame of the running outputs.
   task automatic measure(input int r);
      int   f1, m_a, m_b, s_a, s_b, n_lo, n_hi;
      logic pm;
      f1 = -1; m_a = -1; m_b = -1; s_a = -1; s_b = -1; n_lo = 0; n_hi = 0;
      for (int k = 0; k < 5000 && !bus.frame_stb; k++) tick(1);
      check($sformatf("frame_align_r%0d", r), 32'(bus.frame_stb), 32'd1);
      exp_q.push_back(32'(2048 >> r));
      exp_q.push_back(32'(32 >> r));
      exp_q.push_back(32'(8 >> r));
      exp_q.push_back(32'd32);
      exp_q.push_back(32'd32);
      if (bus.sclk_fall_stb) begin
         if (bus.lrck) n_hi++; else n_lo++;
      end
      pm = bus.mclk;
      for (int c = 1; c <= (2048 >> r) + 4 && f1 < 0; c++) begin
         tick(1);
         if (bus.frame_stb) f1 = c;
         else if (bus.sclk_fall_stb) begin
            if (bus.lrck) n_hi++; else n_lo++;
         end
         if (bus.mclk && !pm) begin
            if (m_a < 0) m_a = c; else if (m_b < 0) m_b = c;
         end
         pm = bus.mclk;
         if (bus.sclk_rise_stb) begin
            if (s_a < 0) s_a = c; else if (s_b < 0) s_b = c;
         end
      end
      check($sformatf("lrck_period_r%0d", r), 32'(f1), exp_q.pop_front());
      check($sformatf("sclk_period_r%0d", r), 32'(s_b - s_a), exp_q.pop_front());
      check($sformatf("mclk_period_r%0d", r), 32'(m_b - m_a), exp_q.pop_front());
      check($sformatf("falls_left_r%0d", r), 32'(n_lo), exp_q.pop_front());
      check($sformatf("falls_right_r%0d", r), 32'(n_hi), exp_q.pop_front());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      tick(3);
      check("reset_state", 32'(obs()), 32'({IDLE, 9'b0_00_000_000}));
      rst = 1'b0;

      //   name              adv   rst lk en sel state    run rate clk  stb
      add("idle_nolock",       4, 0, 0, 1, 0, IDLE,    9'b0_00_000_000);
      add("holdoff_last",    258, 0, 1, 1, 0, HOLDOFF, 9'b0_00_000_000);
      add("run_first",         1, 0, 1, 1, 0, RUN,     9'b1_00_000_000);
      add("r0_cnt4",           4, 0, 1, 1, 0, RUN,     9'b1_00_100_000);
      add("r0_cnt16",         12, 0, 1, 1, 0, RUN,     9'b1_00_010_010);
      add("r0_cnt20",          4, 0, 1, 1, 0, RUN,     9'b1_00_110_000);
      add("r0_cnt32",         12, 0, 1, 1, 0, RUN,     9'b1_00_000_100);
      add("r0_cnt1024",      992, 0, 1, 1, 0, RUN,     9'b1_00_001_100);
      add("r0_cnt1040",       16, 0, 1, 1, 0, RUN,     9'b1_00_011_010);
      add("r0_cnt2047",     1007, 0, 1, 1, 0, RUN,     9'b1_00_111_000);
      add("r0_wrap",           1, 0, 1, 1, 0, RUN,     9'b1_00_000_101);
      add("r0_cnt500",       500, 0, 1, 1, 0, RUN,     9'b1_00_110_000);
      add("sel2_midframe",     1, 0, 1, 1, 2, RUN,     9'b1_00_110_000);
      add("sel2_held",      1546, 0, 1, 1, 2, RUN,     9'b1_00_111_000);
      add("sel2_wrap",         1, 0, 1, 1, 2, RUN,     9'b1_10_000_101);
      add("r2_cnt4",           1, 0, 1, 1, 2, RUN,     9'b1_10_100_000);
      add("r2_cnt16",          3, 0, 1, 1, 2, RUN,     9'b1_10_010_010);
      add("r2_cnt20",          1, 0, 1, 1, 2, RUN,     9'b1_10_110_000);
      add("r2_cnt32",          3, 0, 1, 1, 2, RUN,     9'b1_10_000_100);
      add("sel3_wrap",       504, 0, 1, 1, 3, RUN,     9'b1_10_000_101);
      add("r2_mclk_hi",        1, 0, 1, 1, 3, RUN,     9'b1_10_100_000);
      add("r2_mclk_lo",        1, 0, 1, 1, 3, RUN,     9'b1_10_000_000);
      add("lock_drop_sync",    2, 0, 0, 1, 3, RUN,     9'b1_10_010_010);
      add("lock_drop_idle",    1, 0, 0, 1, 3, IDLE,    9'b0_10_000_000);
      add("idle_sat",          1, 0, 0, 1, 3, IDLE,    9'b0_10_000_000);
      add("idle_sel1",         1, 0, 0, 1, 1, IDLE,    9'b0_01_000_000);
      add("relock_hold",     258, 0, 1, 1, 0, HOLDOFF, 9'b0_00_000_000);
      add("relock_run",        1, 0, 1, 1, 0, RUN,     9'b1_00_000_000);
      add("r0_cnt20b",        20, 0, 1, 1, 0, RUN,     9'b1_00_110_000);
      add("en_drop",           1, 0, 1, 0, 0, IDLE,    9'b0_00_000_000);
      add("en_back",           1, 0, 1, 1, 0, HOLDOFF, 9'b0_00_000_000);
      add("en_hold_last",    255, 0, 1, 1, 0, HOLDOFF, 9'b0_00_000_000);
      add("en_run",            1, 0, 1, 1, 0, RUN,     9'b1_00_000_000);
      add("rst_prep_wrap",  2048, 0, 1, 1, 2, RUN,     9'b1_10_000_101);
      add("rst_prep_cnt20",    5, 0, 1, 1, 2, RUN,     9'b1_10_110_000);
      add("rst_in_run",        1, 1, 1, 1, 2, IDLE,    9'b0_00_000_000);
      add("rst_release",       1, 0, 1, 1, 2, IDLE,    9'b0_10_000_000);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].lk, vecs[i].en, vecs[i].sel);
         tick(vecs[i].adv);
         check(vecs[i].name, 32'(obs()), 32'(vecs[i].exp));
      end

      // Restart at the base rate and measure a full frame, then switch to 192k.
      bus.rate_sel = 2'(RATE_48K);
      for (int k = 0; k < 400 && !bus.running; k++) tick(1);
      check("restart_running", 32'(bus.running), 32'd1);
      measure(RATE_48K);
      bus.rate_sel = 2'(RATE_192K);
      tick(1);
      measure(RATE_192K);

      // ---------------- report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_clk_div.md
Name: i2s_clk_div

Overview:
- Parametrised audio clock-enable generator for the synth audio path, driven by the 98.304 MHz system clock.
- Derives I2S MCLK, SCLK (BCLK) and LRCK as flop outputs, plus single-cycle timing strobes for the serialiser.
- Supports run-time selectable sample rate: 48/96/192 kHz at defaults.
- Qualifies startup on the upstream clock-lock flag, with a hold-off delay.

Parameters:
- SYS_FS_RATIO, 2048, system clocks per LRCK frame at base rate; power of two; W = log2(SYS_FS_RATIO).
- MCLK_PER_FRAME, 256, MCLK cycles per frame; power of two, < SYS_FS_RATIO/2.
- BCLK_PER_FRAME, 64, SCLK cycles per frame; power of two, ≤ MCLK_PER_FRAME.
- RATE_W, 2, width of rate select.
- HOLDOFF_CYCLES, 256, clocks to wait after lock qualifies before running; ≥ 1.
- Derived constant MAX_RATE = log2(SYS_FS_RATIO/MCLK_PER_FRAME) - 1. Default is 2.

Ports:
- clk_in, input, 1: system clock. Single clock domain.
- rst, input, 1: synchronous, active-high reset.
- locked_in, input, 1: upstream clock-gen lock flag. Asynchronous; synchronised internally.
- en, input, 1: run request.
- rate_sel, input, RATE_W: requested rate; fs = base × 2^rate_sel.
- rate_cur, output, RATE_W: rate currently in effect.
- running, output, 1: high while in RUN.
- mclk, output, 1: master clock, 50% duty.
- sclk, output, 1: bit clock, 50% duty.
- lrck, output, 1: word select; 0 = left.
- sclk_fall_stb, output, 1: one-cycle pulse, coincident with the cycle sclk first reads 0.
- sclk_rise_stb, output, 1: one-cycle pulse, coincident with the cycle sclk first reads 1.
- frame_stb, output, 1: one-cycle pulse, coincident with the cycle lrck first reads 0 (new left frame).

Behaviour:
- Reset:
  - state = IDLE, cnt = 0, rate_cur = 0.
  - Sync flops = 0, hold-off counter = 0.
  - All outputs 0.
- locked_in passes through a 2-flop synchroniser → lock_s.
- State machine:
  - IDLE → HOLDOFF when lock_s & en. Hold-off counter cleared.
  - HOLDOFF: counts clocks. → RUN on the cycle the count reaches HOLDOFF_CYCLES-1. → IDLE immediately if !lock_s or !en.
  - RUN → IDLE immediately if !lock_s or !en. cnt forced to 0 on that cycle's update.
- Counter cnt[W-1:0]:
  - Outside RUN: held at 0.
  - In RUN: cnt <= cnt + (1 << rate_cur), modulo 2^W.
  - Wrap (cnt + step == 2^W) is the frame boundary.
- Clock outputs are direct flop bits of cnt (no logic after the flop, so glitch-free):
  - mclk = cnt[log2(SYS_FS_RATIO/MCLK_PER_FRAME)-1]
  - sclk = cnt[log2(SYS_FS_RATIO/BCLK_PER_FRAME)-1]
  - lrck = cnt[W-1]
  - Defaults: mclk = bit 2, sclk = bit 4, lrck = bit 10.
  - Edge alignment: lrck and sclk falling edges coincide by construction.
- Strobes:
  - Registered, computed from cnt and its next value, so each pulse aligns with the output edge it marks.
  - Never asserted outside RUN.
  - The first RUN cycle (cnt = 0) does NOT assert frame_stb or sclk_fall_stb.
- Rate change:
  - rate_sel is sampled continuously. Values > MAX_RATE saturate to MAX_RATE.
  - rate_cur updates only at a frame boundary (wrap) or while not in RUN.
  - A mid-frame change therefore takes effect at the next left-frame start. Never a short or partial period.
  - If rate_sel changes several times within a frame, only the value present at the wrap cycle is used.
- Periods in clk_in cycles at rate r (defaults):
  - mclk: 8>>r
  - sclk: 32>>r
  - lrck: 2048>>r
- Lock loss or en drop mid-frame:
  - Outputs drop to 0 within 1 cycle, truncating the frame. This is acceptable; the downstream serialiser discards the partial frame.
  - Restart always goes through HOLDOFF and begins at cnt = 0.
- rst mid-operation has the same effect as the reset state above, including rate_cur = 0.

Decomposition:
- Package i2s_clk_pkg holds:
  - State enum (IDLE, HOLDOFF, RUN).
  - Rate encodings RATE_48K = 0, RATE_96K = 1, RATE_192K = 2.
  - clog2-based bit-index helper constants.
- Sub-module sync_2ff: the generic 2-flop synchroniser for locked_in, reusable elsewhere.
- Everything else stays in one module.

Test Plan:
1. rst, then locked_in = 1, en = 1, rate_sel = 0 → running rises 2 + 256 cycles (±1) after lock. Then:
   - mclk period 8, sclk period 32, lrck period 2048.
   - frame_stb every 2048 cycles.
   - 32 sclk_fall_stb per lrck half.
2. rate_sel 0 → 2 asserted at cnt = 500 → rate_cur stays 0 until wrap (cnt 2047 → 0), then lrck period 512, sclk period 8, mclk period 2. No short pulse on any output.
3. rate_sel = 3 → rate_cur = 2 (saturated); mclk toggles every cycle.
4. locked_in drops mid-frame → running = 0 and all outputs 0 within sync latency + 1. Relock → full HOLDOFF, restart at cnt = 0 with lrck = 0.
5. en toggled low for 1 cycle during RUN → returns to IDLE, then a new 256-cycle HOLDOFF before RUN.
6. Synchronous rst asserted during RUN at rate 2 → next cycle all outputs 0, rate_cur = 0, state IDLE.
